query_patch_loader: RTL and testbench
=====================================

Name: query_patch_loader

Overview:
- Sits directly downstream of the accelerator's input FIFO (11-bit words on the io_clk side, read out on the accelerator clock).
- Assembles PATCH_SIZE consecutive words into one query patch and writes each patch into the query-patch memory at incrementing addresses.
- On load_kdtree-style start, loads NUM_QUERYS patches, then pulses done.
- Feeds the same memory port format the wishbone debug path uses: active-low csb0/web0, 9-bit address, 55-bit patch.

Parameters:
- DATA_WIDTH, 11: bits per FIFO word and per patch element.
- PATCH_SIZE, 5: words per patch; patch width = DATA_WIDTH*PATCH_SIZE = 55.
- NUM_QUERYS, 512: patches per load; must be >= 1 and <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 9: query-patch memory address width.

Ports:
- clk  input  1  accelerator clock; single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle load request.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the final patch has been written.
- fifo_rempty_n  input  1  FIFO non-empty; fifo_rdata is valid while high (show-ahead).
- fifo_rdata  input  DATA_WIDTH  head word of the FIFO.
- fifo_deq  output  1  pops the head word this cycle.
- mem_csb0  output  1  query-patch memory chip select, active-low.
- mem_web0  output  1  write enable, active-low.
- mem_addr0  output  ADDR_WIDTH  write address.
- mem_wpatch0  output  DATA_WIDTH*PATCH_SIZE  write data.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE; busy=0, done=0, fifo_deq=0.
  - mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wpatch0=0.
  - Word index, patch counter and patch register = 0.
- States:
  - IDLE: start=1 -> LOAD, clearing the word index and patch counter. Otherwise stay.
  - LOAD:
    - fifo_deq = fifo_rempty_n (combinational; never asserted when the FIFO is empty).
    - On each deq, fifo_rdata is stored in slice [idx*DATA_WIDTH +: DATA_WIDTH]. The first word lands in bits [10:0]; the fifth in [54:44].
    - idx increments on each deq. A deq at idx=PATCH_SIZE-1 -> WRITE, and idx returns to 0.
    - With fifo_rempty_n=0, stay in LOAD with no state change; there is no timeout.
  - WRITE (exactly 1 cycle):
    - mem_csb0=0, mem_web0=0, mem_addr0=patch counter, mem_wpatch0=assembled patch. These are registered outputs valid during this cycle.
    - fifo_deq=0.
    - If patch counter == NUM_QUERYS-1 -> DONE. Otherwise increment the counter and go to LOAD.
  - DONE (1 cycle): done=1, busy=0, then -> IDLE.
- Outside WRITE: mem_csb0=1 and mem_web0=1. mem_addr0 and mem_wpatch0 hold their last values.
- busy=1 in LOAD and WRITE only.
- Latency:
  - First deq can occur the cycle after start.
  - The write cycle follows the cycle of the 5th deq.
  - With a continuously non-empty FIFO, one patch takes PATCH_SIZE+1 cycles.
  - done occurs the cycle after the final write.
- Boundaries:
  - start while in LOAD, WRITE or DONE is ignored.
  - Address counter: last address is NUM_QUERYS-1 (511 at default). It never wraps within a load and restarts at 0 on the next accepted start.
  - No arithmetic is performed on data; words pass through bit-exact.
  - Reset mid-operation discards the partial patch with no memory write. The next start begins at address 0.
  - Words left in the FIFO after done are not consumed.

Test Plan:
- Reset asserted mid-cycle with no clock edge -> immediately: busy=0, done=0, fifo_deq=0, mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wpatch0=0.
- NUM_QUERYS=4, FIFO preloaded with words 0x001..0x014, start pulse:
  - Exactly 4 writes, to addr 0..3.
  - addr0 data = {0x005,0x004,0x003,0x002,0x001}; addr3 data = {0x014,...,0x010}.
  - Writes are spaced 6 cycles apart.
  - done is a single pulse one cycle after the addr3 write; busy drops with it.
- Same stimulus with fifo_rempty_n toggling 1,0,0,1,...:
  - fifo_deq is never high while fifo_rempty_n=0.
  - Written data and addresses are identical to the previous scenario; only timing stretches.
- start pulsed again during LOAD and during DONE -> no restart; the patch counter is unaffected and still exactly 4 writes occur.
- Async reset after 3 words of patch 1:
  - No write occurs.
  - A new start with words 0x100..0x104 writes addr 0 with {0x104,0x103,0x102,0x101,0x100}.
- Default NUM_QUERYS=512, all words 0x7FF:
  - 512 writes, last at addr 511 with data 55'h7F_FFFF_FFFF_FFFF.
  - done pulses once.
  - A second start begins again at addr 0.

Source files
------------

// File: rtl/query_patch_loader.sv
// query_patch_loader
// Pulls DATA_WIDTH-bit words from a show-ahead FIFO, packs PATCH_SIZE of them
// into one query patch and writes each patch into the query-patch memory at
// incrementing addresses. A load of NUM_QUERYS patches ends with a one-cycle
// done pulse. The memory port uses active-low chip select / write enable, the
// same format the debug path drives.
//
// FIFO handshake (show-ahead, valid/ready style): fifo_rempty_n acts as valid
// and fifo_rdata is the head word whenever it is high; fifo_deq acts as ready.
// A word is transferred in exactly the cycles where fifo_rempty_n and fifo_deq
// are both high. fifo_deq never rises without fifo_rempty_n, and the head word
// is sampled on the same clock edge that pops it.

module query_patch_loader #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_QUERYS = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    input  logic                             fifo_rempty_n,
    input  logic [DATA_WIDTH-1:0]            fifo_rdata,
    output logic                             fifo_deq,
    output logic                             mem_csb0,
    output logic                             mem_web0,
    output logic [ADDR_WIDTH-1:0]            mem_addr0,
    output logic [DATA_WIDTH*PATCH_SIZE-1:0] mem_wpatch0
);

    localparam int PATCH_WIDTH = DATA_WIDTH * PATCH_SIZE;
    // Word index needs at least one bit even for single-word patches.
    localparam int IDX_W = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(PATCH_SIZE - 1);
    // NUM_QUERYS may equal 2**ADDR_WIDTH, so the last address always fits.
    localparam logic [ADDR_WIDTH-1:0] LAST_PATCH = ADDR_WIDTH'(NUM_QUERYS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic [ADDR_WIDTH-1:0]   patch_cnt;
    logic [ADDR_WIDTH-1:0]   patch_cnt_nxt;
    logic [PATCH_WIDTH-1:0]  patch_reg;
    logic [PATCH_WIDTH-1:0]  patch_nxt;
    // High in the cycle of the last deq of a patch: the following cycle is
    // the memory write, so the memory port registers load from here.
    logic                    wr_issue;

    // State register; reset drops any partial patch and returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, FIFO pop, word placement and status decode.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        patch_cnt_nxt = patch_cnt;
        patch_nxt     = patch_reg;
        fifo_deq      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        wr_issue      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = LOAD;
                    idx_nxt       = '0;
                    patch_cnt_nxt = '0;
                end
            end

            LOAD: begin
                busy     = 1'b1;
                fifo_deq = fifo_rempty_n;
                if (fifo_rempty_n) begin
                    // Word k of a patch occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
                    for (int i = 0; i < PATCH_SIZE; i++) begin
                        if (idx == IDX_W'(i)) begin
                            patch_nxt[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = WRITE;
                        wr_issue  = 1'b1;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end

            WRITE: begin
                busy = 1'b1;
                if (patch_cnt == LAST_PATCH) begin
                    state_nxt = DONE;
                end else begin
                    patch_cnt_nxt = patch_cnt + ADDR_WIDTH'(1);
                    state_nxt     = LOAD;
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Word index, patch counter and patch assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            patch_cnt <= '0;
            patch_reg <= '0;
        end else begin
            idx       <= idx_nxt;
            patch_cnt <= patch_cnt_nxt;
            patch_reg <= patch_nxt;
        end
    end

    // Registered memory port: strobes are low only in the WRITE cycle, and
    // address/data hold their last written values in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_csb0    <= 1'b1;
            mem_web0    <= 1'b1;
            mem_addr0   <= '0;
            mem_wpatch0 <= '0;
        end else begin
            mem_csb0 <= ~wr_issue;
            mem_web0 <= ~wr_issue;
            if (wr_issue) begin
                mem_addr0   <= patch_cnt;
                mem_wpatch0 <= patch_nxt;
            end
        end
    end

endmodule

// File: tb/tb_query_patch_loader.sv
// Directed bench for query_patch_loader: a 4-patch instance fed from a queue
// FIFO model and a default 512-patch instance fed a constant 0x7FF stream.

module tb_query_patch_loader;

    localparam int DW = 11;
    localparam int AW = 9;
    localparam int PW = 55;

    logic clk;
    logic rst_n;

    logic          start_a, busy_a, done_a, fifo_rempty_n_a, fifo_deq_a;
    logic          mem_csb0_a, mem_web0_a;
    logic [DW-1:0] fifo_rdata_a;
    logic [AW-1:0] mem_addr0_a;
    logic [PW-1:0] mem_wpatch0_a;

    logic          start_b, busy_b, done_b, fifo_rempty_n_b, fifo_deq_b;
    logic          mem_csb0_b, mem_web0_b;
    logic [DW-1:0] fifo_rdata_b;
    logic [AW-1:0] mem_addr0_b;
    logic [PW-1:0] mem_wpatch0_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // FIFO model for instance a
    logic [DW-1:0] qa[$];
    logic          mask_a   = 1'b1;
    logic          toggle_a = 1'b0;
    int            phase_a  = 0;
    logic          pop_a;

    // Write / done logs for instance a
    logic [AW-1:0] wa_addr[$];
    logic [PW-1:0] wa_data[$];
    int            wa_cyc[$];
    logic          wa_busy[$];
    int            done_a_cnt;
    int            done_a_cyc;
    logic          done_a_busy;
    int            viol_a;

    // Logs for instance b
    logic          feed_b;
    int            wb_cnt;
    int            wb_seq_err;
    int            done_b_cnt;
    logic [AW-1:0] wb_last_addr;
    logic [PW-1:0] wb_last_data;

    assign fifo_rempty_n_b = feed_b;
    assign fifo_rdata_b    = 11'h7FF;

    query_patch_loader #(.NUM_QUERYS(4)) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_a),
        .busy          (busy_a),
        .done          (done_a),
        .fifo_rempty_n (fifo_rempty_n_a),
        .fifo_rdata    (fifo_rdata_a),
        .fifo_deq      (fifo_deq_a),
        .mem_csb0      (mem_csb0_a),
        .mem_web0      (mem_web0_a),
        .mem_addr0     (mem_addr0_a),
        .mem_wpatch0   (mem_wpatch0_a)
    );

    query_patch_loader dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_b),
        .busy          (busy_b),
        .done          (done_b),
        .fifo_rempty_n (fifo_rempty_n_b),
        .fifo_rdata    (fifo_rdata_b),
        .fifo_deq      (fifo_deq_b),
        .mem_csb0      (mem_csb0_b),
        .mem_web0      (mem_web0_b),
        .mem_addr0     (mem_addr0_b),
        .mem_wpatch0   (mem_wpatch0_b)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Refresh the show-ahead FIFO outputs of instance a from the queue.
    task automatic upd_a();
        fifo_rempty_n_a = mask_a && (qa.size() != 0);
        fifo_rdata_a    = (qa.size() != 0) ? qa[0] : '0;
    endtask

    // FIFO model: pop sampled at the edge, queue updated just after it.
    always @(posedge clk) begin
        pop_a = fifo_deq_a;
        #1;
        if (pop_a && qa.size() != 0) void'(qa.pop_front());
        if (toggle_a) begin
            mask_a  = (phase_a == 0);
            phase_a = (phase_a == 2) ? 0 : phase_a + 1;
        end
        upd_a();
    end

    // Output logger on the falling edge.
    always @(negedge clk) begin
        if (!mem_csb0_a && !mem_web0_a) begin
            wa_addr.push_back(mem_addr0_a);
            wa_data.push_back(mem_wpatch0_a);
            wa_cyc.push_back(cyc);
            wa_busy.push_back(busy_a);
        end
        if (done_a) begin
            done_a_cnt++;
            done_a_cyc  = cyc;
            done_a_busy = busy_a;
        end
        if (fifo_deq_a && !fifo_rempty_n_a) viol_a++;
        if (!mem_csb0_b && !mem_web0_b) begin
            if (mem_addr0_b != wb_cnt[AW-1:0]) wb_seq_err++;
            wb_cnt++;
            wb_last_addr = mem_addr0_b;
            wb_last_data = mem_wpatch0_b;
        end
        if (done_b) done_b_cnt++;
    end

    // Driver / checker helpers
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log_a();
        wa_addr.delete();
        wa_data.delete();
        wa_cyc.delete();
        wa_busy.delete();
        done_a_cnt = 0;
        done_a_cyc = 0;
        viol_a     = 0;
    endtask

    task automatic load_a(input int first, input int n);
        for (int k = 0; k < n; k++) qa.push_back(DW'(first + k));
        upd_a();
    endtask

    function automatic logic [PW-1:0] patch_of(input int base);
        logic [PW-1:0] p;
        p = '0;
        for (int j = 0; j < 5; j++) p[j*DW +: DW] = DW'(base + j);
        return p;
    endfunction

    task automatic pulse_start_a(output int sc);
        start_a = 1'b1;
        sc      = cyc;
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int max, input string tag);
        int n;
        n = 0;
        while (!done_a && n < max) begin
            step();
            n++;
        end
        chk(tag, 64'(done_a), 64'd1);
        step();
    endtask

    task automatic check_four_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(wa_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wa_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), 64'(wa_addr[i]), 64'(i));
                chk($sformatf("%s_data%0d", tag, i), 64'(wa_data[i]), 64'(patch_of(5*i + 1)));
            end
        end
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_busy"},   64'(busy_a),        64'd0);
        chk({tag, "_done"},   64'(done_a),        64'd0);
        chk({tag, "_deq"},    64'(fifo_deq_a),    64'd0);
        chk({tag, "_csb"},    64'(mem_csb0_a),    64'd1);
        chk({tag, "_web"},    64'(mem_web0_a),    64'd1);
        chk({tag, "_addr"},   64'(mem_addr0_a),   64'd0);
        chk({tag, "_wpatch"}, 64'(mem_wpatch0_a), 64'd0);
    endtask

    // Directed sequence
    initial begin
        int sc;
        int n;

        rst_n      = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        feed_b     = 1'b0;
        wb_cnt     = 0;
        wb_seq_err = 0;
        done_b_cnt = 0;
        upd_a();
        clear_log_a();

        // Reset asserted before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check_reset_a("rst0");
        chk("rst0_b_csb", 64'(mem_csb0_b), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // Scenario 1: 20 words, continuous FIFO
        load_a(1, 20);
        clear_log_a();
        pulse_start_a(sc);
        wait_done_a(100, "s1_done_seen");
        check_four_writes("s1");
        if (wa_cyc.size() == 4) begin
            chk("s1_first_latency", 64'(wa_cyc[0] - sc), 64'd6);
            for (int i = 1; i < 4; i++)
                chk($sformatf("s1_spacing%0d", i), 64'(wa_cyc[i] - wa_cyc[i-1]), 64'd6);
            chk("s1_done_after_last", 64'(done_a_cyc - wa_cyc[3]), 64'd1);
            chk("s1_busy_in_write", 64'(wa_busy[0]), 64'd1);
        end
        chk("s1_done_pulses", 64'(done_a_cnt), 64'd1);
        chk("s1_busy_at_done", 64'(done_a_busy), 64'd0);
        chk("s1_busy_after", 64'(busy_a), 64'd0);
        chk("s1_fifo_left", 64'(qa.size()), 64'd0);

        // Scenario 2: same words, valid toggling 1,0,0
        load_a(1, 20);
        clear_log_a();
        phase_a  = 0;
        toggle_a = 1'b1;
        pulse_start_a(sc);
        wait_done_a(300, "s2_done_seen");
        toggle_a = 1'b0;
        mask_a   = 1'b1;
        upd_a();
        check_four_writes("s2");
        chk("s2_deq_while_empty", 64'(viol_a), 64'd0);
        chk("s2_done_pulses", 64'(done_a_cnt), 64'd1);
        if (wa_cyc.size() >= 2)
            chk("s2_stretched", 64'(wa_cyc[1] - wa_cyc[0] > 6), 64'd1);

        // Scenario 3: start during LOAD and during DONE is ignored
        load_a(1, 25);
        clear_log_a();
        pulse_start_a(sc);
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 100) begin
            step();
            n++;
        end
        chk("s3_done_seen", 64'(done_a), 64'd1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (20) step();
        check_four_writes("s3");
        chk("s3_done_pulses", 64'(done_a_cnt), 64'd1);
        chk("s3_busy_idle", 64'(busy_a), 64'd0);
        chk("s3_words_left", 64'(qa.size()), 64'd5);

        // Scenario 4: async reset after 3 words of the first patch
        qa.delete();
        load_a(1, 20);
        clear_log_a();
        pulse_start_a(sc);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check_reset_a("rst1");
        chk("s4_words_taken", 64'(qa.size()), 64'd17);
        @(negedge clk);
        qa.delete();
        upd_a();
        rst_n = 1'b1;
        step();
        chk("s4_no_write", 64'(wa_addr.size()), 64'd0);
        load_a(256, 5);
        pulse_start_a(sc);
        n = 0;
        while (wa_addr.size() == 0 && n < 50) begin
            step();
            n++;
        end
        chk("s4_nwrites", 64'(wa_addr.size()), 64'd1);
        if (wa_addr.size() != 0) begin
            chk("s4_addr", 64'(wa_addr[0]), 64'd0);
            chk("s4_data", 64'(wa_data[0]), 64'(patch_of(256)));
        end
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();

        // Scenario 5: default 512-patch load, all 0x7FF
        wb_cnt     = 0;
        wb_seq_err = 0;
        done_b_cnt = 0;
        feed_b     = 1'b1;
        start_b    = 1'b1;
        step();
        start_b    = 1'b0;
        n = 0;
        while (!done_b && n < 4000) begin
            step();
            n++;
        end
        chk("s5_done_seen", 64'(done_b), 64'd1);
        step();
        chk("s5_nwrites", 64'(wb_cnt), 64'd512);
        chk("s5_last_addr", 64'(wb_last_addr), 64'd511);
        chk("s5_last_data", 64'(wb_last_data), 64'h007F_FFFF_FFFF_FFFF);
        chk("s5_addr_seq", 64'(wb_seq_err), 64'd0);
        chk("s5_done_pulses", 64'(done_b_cnt), 64'd1);
        chk("s5_busy_after", 64'(busy_b), 64'd0);

        wb_cnt       = 0;
        wb_seq_err   = 0;
        wb_last_addr = '1;
        start_b      = 1'b1;
        step();
        start_b      = 1'b0;
        n = 0;
        while (wb_cnt == 0 && n < 50) begin
            step();
            n++;
        end
        chk("s5_restart_write", 64'(wb_cnt != 0), 64'd1);
        chk("s5_restart_addr", 64'(wb_last_addr), 64'd0);
        feed_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
